// File: rtl/uart_pkg.sv
// Shared definitions for the UART-side register command responder:
// FSM state encoding, default response bytes and command field layout.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_DATA = 3'd1,
    ST_REG_WR   = 3'd2,
    ST_REG_RD   = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_SEND     = 3'd5,
    ST_WAIT_HI  = 3'd6,
    ST_WAIT_LO  = 3'd7
  } state_e;

  localparam logic [7:0]  ACK_BYTE_DEF  = 8'h06;
  localparam logic [7:0]  NAK_BYTE_DEF  = 8'h15;
  localparam int unsigned CMD_WR_BIT    = 32'd7;
  localparam logic [7:0]  CMD_RSVD_MASK = 8'h70;

  // Reserved bits 6:4 must be zero for a command to be honoured.
  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    return ((cmd & CMD_RSVD_MASK) == 8'h00);
  endfunction

endpackage

// File: rtl/uart_timeout_counter.sv
// Saturating cycle counter used to bound the data-byte and transmitter-accept waits.
// Counts while enabled, saturates at TIMEOUT_CYCLES and reports expiry there.
module uart_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/uart_reg_responder.sv
// Decodes single-byte register read/write commands from the UART receiver,
// drives the register bus and returns one ACK/NAK/read-data byte to the transmitter.
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_data_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_par_error,
  input  logic                  rx_frame_error,
  output logic                  tx_data_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr_en,
  output logic [7:0]            reg_wr_data,
  output logic                  reg_rd_en,
  input  logic [7:0]            reg_rd_data,
  output logic                  busy,
  output logic                  rx_overrun
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  overrun_q, overrun_d;
  logic                  to_clear, to_en, to_expired;
  logic                  rx_err;

  assign rx_err = rx_par_error | rx_frame_error;
  assign to_en  = (state_q == ST_GET_DATA) || (state_q == ST_WAIT_HI);

  uart_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (to_clear),
    .enable (to_en),
    .expired(to_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    to_clear  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_data_valid) begin
          if (rx_err || !cmd_is_valid(rx_data)) begin
            tx_data_d = NAK_BYTE;
            state_d   = ST_SEND;
          end else if (rx_data[CMD_WR_BIT]) begin
            addr_d   = rx_data[ADDR_WIDTH-1:0];
            to_clear = 1'b1;
            state_d  = ST_GET_DATA;
          end else begin
            addr_d  = rx_data[ADDR_WIDTH-1:0];
            state_d = ST_REG_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        // A byte arriving on the expiry cycle still wins over the timeout.
        if (rx_data_valid) begin
          if (rx_err) begin
            tx_data_d = NAK_BYTE;
            state_d   = ST_SEND;
          end else begin
            wr_data_d = rx_data;
            state_d   = ST_REG_WR;
          end
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GET_DATA;
        end
      end
      ST_REG_WR: begin
        tx_data_d = ACK_BYTE;
        state_d   = ST_SEND;
      end
      ST_REG_RD: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        tx_data_d = reg_rd_data;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          to_clear = 1'b1;
          state_d  = ST_WAIT_HI;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LO;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bytes that arrive while a response is in progress are lost; remember that.
  always_comb begin
    overrun_d = overrun_q;
    if (rx_data_valid && (state_q != ST_IDLE) && (state_q != ST_GET_DATA)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_data_q <= 8'h00;
      tx_data_q <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      overrun_q <= overrun_d;
    end
  end

  // Launch is qualified by the live busy input so a free transmitter is used the same cycle.
  assign tx_data_valid = (state_q == ST_SEND) && !tx_busy;
  assign tx_data       = tx_data_q;
  assign reg_addr      = addr_q;
  assign reg_wr_data   = wr_data_q;
  assign reg_wr_en     = (state_q == ST_REG_WR);
  assign reg_rd_en     = (state_q == ST_REG_RD);
  assign busy          = (state_q != ST_IDLE);
  assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: expected response bytes are queued
// as commands are driven and compared when the DUT launches them.
module tb_uart_reg_responder;

  localparam int unsigned TO = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_data_valid;
  logic [7:0] rx_data;
  logic       rx_par_error;
  logic       rx_frame_error;
  logic       tx_data_valid;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic [3:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data;
  logic       busy;
  logic       rx_overrun;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int n_pushed = 0;
  int n_launch = 0;
  int n_served = 0;
  int n_wr = 0;
  int n_rd = 0;
  int busy_cnt = 0;
  bit tx_hold_hi = 1'b0;
  bit tx_mute = 1'b0;

  uart_reg_responder #(
    .ADDR_WIDTH(4),
    .TIMEOUT_CYCLES(TO),
    .ACK_BYTE(8'h06),
    .NAK_BYTE(8'h15)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_data_valid(rx_data_valid), .rx_data(rx_data),
    .rx_par_error(rx_par_error), .rx_frame_error(rx_frame_error),
    .tx_data_valid(tx_data_valid), .tx_data(tx_data), .tx_busy(tx_busy),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .busy(busy), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_tx(input logic [7:0] b);
    exp_q.push_back(b);
    n_pushed++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par, input logic frm);
    @(posedge clk); #1;
    rx_data_valid = 1'b1; rx_data = b; rx_par_error = par; rx_frame_error = frm;
    @(posedge clk); #1;
    rx_data_valid = 1'b0; rx_par_error = 1'b0; rx_frame_error = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy && (i < budget)) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_launch(input string tag, input int n0, input int budget);
    int i;
    i = 0;
    while ((n_launch == n0) && (i < budget)) begin
      @(negedge clk); #1;
      i++;
    end
    check_eq(tag, 32'(n_launch - n0), 32'd1);
  endtask

  // Monitor: scoreboard compare on every launch, strobe counting.
  always @(negedge clk) begin
    if (reg_wr_en) n_wr++;
    if (reg_rd_en) n_rd++;
    if (tx_data_valid) begin
      n_launch++;
      check_eq("tx_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_eq("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // Transmitter model: goes busy for four cycles after each launch unless muted or forced.
  always @(posedge clk) begin
    #1;
    if (tx_hold_hi) begin
      tx_busy = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      tx_busy = (busy_cnt > 0);
    end else if (n_launch != n_served) begin
      n_served = n_launch;
      tx_busy  = !tx_mute;
      busy_cnt = tx_mute ? 0 : 4;
    end else begin
      tx_busy = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int w0, r0, l0;
    reset = 1'b1; rx_data_valid = 1'b0; rx_data = 8'h00;
    rx_par_error = 1'b0; rx_frame_error = 1'b0; reg_rd_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_valid", 32'(tx_data_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'h00);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_strobes", 32'({reg_wr_en, reg_rd_en}), 32'd0);
    check_eq("rst_addr", 32'(reg_addr), 32'd0);
    check_eq("rst_overrun", 32'(rx_overrun), 32'd0);
    reset = 1'b0;

    // Write: CMD 0x83, DATA 0x5A -> strobe at k+1, ACK at k+2
    w0 = n_wr;
    expect_tx(8'h06);
    send_byte(8'h83, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("wr_en", 32'(reg_wr_en), 32'd1);
    check_eq("wr_addr", 32'(reg_addr), 32'd3);
    check_eq("wr_data", 32'(reg_wr_data), 32'h5A);
    @(negedge clk);
    check_eq("wr_ack_valid", 32'(tx_data_valid), 32'd1);
    check_eq("wr_ack_data", 32'(tx_data), 32'h06);
    wait_idle("wr_idle", 20);
    check_eq("wr_single_strobe", 32'(n_wr - w0), 32'd1);

    // Read: CMD 0x07 -> rd_en at 1, launch at 3
    reg_rd_data = 8'hC3;
    expect_tx(8'hC3);
    send_byte(8'h07, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("rd_en", 32'(reg_rd_en), 32'd1);
    check_eq("rd_addr", 32'(reg_addr), 32'd7);
    @(negedge clk);
    check_eq("rd_no_early_tx", 32'(tx_data_valid), 32'd0);
    @(negedge clk);
    check_eq("rd_tx_valid", 32'(tx_data_valid), 32'd1);
    check_eq("rd_tx_data", 32'(tx_data), 32'hC3);
    wait_idle("rd_idle", 20);

    // Invalid command 0x93 -> NAK one cycle later, no register access
    w0 = n_wr; r0 = n_rd;
    expect_tx(8'h15);
    send_byte(8'h93, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("inv_nak_valid", 32'(tx_data_valid), 32'd1);
    check_eq("inv_nak_data", 32'(tx_data), 32'h15);
    wait_idle("inv_idle", 20);
    check_eq("inv_no_strobe", 32'((n_wr - w0) + (n_rd - r0)), 32'd0);

    // Parity error on DATA byte -> NAK, no write
    w0 = n_wr;
    expect_tx(8'h15);
    send_byte(8'h82, 1'b0, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("par_nak_valid", 32'(tx_data_valid), 32'd1);
    wait_idle("par_idle", 20);
    check_eq("par_no_wr", 32'(n_wr - w0), 32'd0);

    // Frame error on CMD byte -> NAK
    expect_tx(8'h15);
    send_byte(8'h01, 1'b0, 1'b1);
    wait_idle("frm_idle", 20);

    // Data-byte timeout: silent return to IDLE
    l0 = n_launch; w0 = n_wr;
    send_byte(8'h85, 1'b0, 1'b0);
    repeat (45) @(negedge clk);
    check_eq("to_data_still_busy", 32'(busy), 32'd1);
    wait_idle("to_data_idle", 15);
    check_eq("to_data_silent", 32'((n_launch - l0) + (n_wr - w0)), 32'd0);

    // Transmitter never goes busy: WAIT_HI times out
    tx_mute = 1'b1;
    reg_rd_data = 8'h3C;
    expect_tx(8'h3C);
    l0 = n_launch;
    send_byte(8'h01, 1'b0, 1'b0);
    wait_launch("mute_launch", l0, 10);
    repeat (45) @(negedge clk);
    check_eq("mute_still_busy", 32'(busy), 32'd1);
    wait_idle("mute_idle", 15);
    tx_mute = 1'b0;

    // Backpressure: launch withheld while tx_busy held high
    tx_hold_hi = 1'b1;
    repeat (2) @(negedge clk);
    expect_tx(8'h15);
    l0 = n_launch;
    send_byte(8'hF0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    check_eq("bp_held_busy", 32'(busy), 32'd1);
    check_eq("bp_withheld", 32'(n_launch - l0), 32'd0);
    tx_hold_hi = 1'b0;
    wait_launch("bp_release_launch", l0, 10);
    wait_idle("bp_idle", 20);

    // Overrun: byte arriving during WAIT_LO is dropped
    check_eq("ovr_clear_before", 32'(rx_overrun), 32'd0);
    reg_rd_data = 8'hA5;
    expect_tx(8'hA5);
    l0 = n_launch; r0 = n_rd;
    send_byte(8'h02, 1'b0, 1'b0);
    wait_launch("ovr_launch", l0, 10);
    @(negedge clk);
    send_byte(8'h04, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("ovr_flag", 32'(rx_overrun), 32'd1);
    wait_idle("ovr_idle", 20);
    repeat (5) @(negedge clk);
    check_eq("ovr_dropped_no_rd", 32'(n_rd - r0), 32'd1);
    check_eq("ovr_sticky", 32'(rx_overrun), 32'd1);

    // Reset asserted in RD_WAIT aborts immediately
    reg_rd_data = 8'h99;
    send_byte(8'h07, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("rstmid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rstmid_tx_valid", 32'(tx_data_valid), 32'd0);
    check_eq("rstmid_tx_data", 32'(tx_data), 32'h00);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_addr", 32'(reg_addr), 32'd0);
    check_eq("rstmid_overrun", 32'(rx_overrun), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Next command after reset is served normally
    reg_rd_data = 8'h5C;
    expect_tx(8'h5C);
    l0 = n_launch;
    send_byte(8'h0A, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("post_rst_rd_en", 32'(reg_rd_en), 32'd1);
    check_eq("post_rst_addr", 32'(reg_addr), 32'hA);
    wait_launch("post_rst_launch", l0, 10);
    wait_idle("post_rst_idle", 20);

    repeat (5) @(negedge clk);
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check_eq("launch_count", 32'(n_launch), 32'(n_pushed));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
